// File: rtl/digit_sequence_gen.sv
// rtl/digit_sequence_gen.sv - fills a sequence RAM with pseudo-random decimal digits for the Orion memory game
// Optional build macro: NO_REPEAT_EN (adjacent stored digits always differ)
module digit_sequence_gen #(
    parameter int          DEPTH  = 32,
    parameter int          ADDR_W = 5,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_gen,
    input  logic [5:0]        seq_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_data,
    output logic              fin_gen,
    output logic              seq_rdy,
    output logic [5:0]        len_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } genState_t;

    // An all-zero seed would lock the LFSR at zero forever
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [5:0]  MAX_LEN   = 6'(DEPTH);
    localparam logic [3:0]  BLANK     = 4'hF;

    genState_t         state;
    genState_t         nextState;
    logic [15:0]       lfsr;
    logic [ADDR_W-1:0] wrPtr;
    logic [5:0]        clampedLen;
    logic [3:0]        rawNibble;
    logic [3:0]        candDigit;
    logic [3:0]        wrDigit;
    logic              lastWrite;
    logic [3:0]        seqMem [DEPTH];
`ifdef NO_REPEAT_EN
    logic [3:0]        prevDigit;
`endif

    // Free-running Galois LFSR; advancing in every state makes the sequence depend on go_gen timing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // Fold the raw nibble into 0..9 and, optionally, break repeats against the previous digit
    always_comb begin
        rawNibble = lfsr[3:0];
        candDigit = (rawNibble >= 4'd10) ? (rawNibble - 4'd10) : rawNibble;
        wrDigit   = candDigit;
`ifdef NO_REPEAT_EN
        if ((wrPtr != '0) && (candDigit == prevDigit)) begin
            wrDigit = (candDigit == 4'd9) ? 4'd0 : (candDigit + 4'd1);
        end
`endif
    end

    // Requested length limited to 1..DEPTH; last write detected against the latched length
    always_comb begin
        clampedLen = seq_len;
        if (seq_len == 6'd0) begin
            clampedLen = 6'd1;
        end else if (seq_len > MAX_LEN) begin
            clampedLen = MAX_LEN;
        end
        lastWrite = (state == FILL) && (6'(wrPtr) == (len_out - 6'd1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; fin_gen is high for the single DONE cycle
    always_comb begin
        nextState = state;
        fin_gen   = 1'b0;
        case (state)
            IDLE: begin
                if (go_gen) begin
                    nextState = FILL;
                end
            end
            FILL: begin
                if (lastWrite) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                fin_gen   = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Length latch, write pointer and sequence-valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_out <= 6'd0;
            seq_rdy <= 1'b0;
            wrPtr   <= '0;
        end else begin
            if ((state == IDLE) && go_gen) begin
                len_out <= clampedLen;
                seq_rdy <= 1'b0;
                wrPtr   <= '0;
            end else if (state == FILL) begin
                if (lastWrite) begin
                    seq_rdy <= 1'b1;
                end else begin
                    wrPtr <= wrPtr + 1'b1;
                end
            end
        end
    end

`ifdef NO_REPEAT_EN
    // Remember the digit just written so the next one can avoid repeating it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prevDigit <= 4'd0;
        end else if (state == FILL) begin
            prevDigit <= wrDigit;
        end
    end
`endif

    // Sequence RAM write port; contents are not reset, seq_rdy guards their validity
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            seqMem[wrPtr] <= wrDigit;
        end
    end

    // Registered read port returning the blank code for invalid or out-of-range reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= BLANK;
        end else if (seq_rdy && (6'(rd_addr) < len_out)) begin
            rd_data <= seqMem[rd_addr];
        end else begin
            rd_data <= BLANK;
        end
    end

endmodule

// File: tb/tb_digit_sequence_gen.sv
// tb/tb_digit_sequence_gen.sv - self-checking bench for digit_sequence_gen
`timescale 1ns/1ps
module tb_digit_sequence_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       go_gen;
    logic [5:0] seq_len;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic       fin_gen;
    logic       seq_rdy;
    logic [5:0] len_out;

    int nTests = 0;
    int nFail  = 0;

    logic [15:0] modelLfsr;
    logic [3:0]  expDig [32];
    int          expLen;

    always #5 clk = ~clk;

    digit_sequence_gen dut (
        .clk     (clk),
        .rst     (rst),
        .go_gen  (go_gen),
        .seq_len (seq_len),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .fin_gen (fin_gen),
        .seq_rdy (seq_rdy),
        .len_out (len_out)
    );

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference LFSR advancing once per clock since reset
    always @(posedge clk or negedge rst) begin
        if (!rst) modelLfsr <= 16'hACE1;
        else      modelLfsr <= lfsrStep(modelLfsr);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected digits: write j uses the LFSR value j+1 clocks after the go_gen edge
    task automatic buildExpected(input logic [5:0] len);
        logic [15:0] l;
        int d;
        int prev;
        expLen = (len == 0) ? 1 : ((len > 32) ? 32 : int'(len));
        l = modelLfsr;
        prev = -1;
        for (int j = 0; j < expLen; j++) begin
            l = lfsrStep(l);
            d = int'(l[3:0]) % 10;
`ifdef NO_REPEAT_EN
            if (j > 0 && d == prev) d = (d + 1) % 10;
`endif
            expDig[j] = 4'(d);
            prev = d;
        end
    endtask

    task automatic runFill(input logic [5:0] len, input bit midGo);
        int  cnt;
        bit  seen;
        int  extra;
        logic [3:0] prevRead;
        seq_len = len;
        rd_addr = 5'd0;
        buildExpected(len);
        go_gen = 1'b1;
        @(negedge clk);
        go_gen = 1'b0;
        cnt  = 1;
        seen = 1'b0;
        while (cnt < 100) begin
            if (fin_gen) begin
                seen = 1'b1;
                break;
            end
            if (cnt >= 2) chk("read_during_fill", 16'(rd_data), 16'hF);
            go_gen = (midGo && cnt == 2);
            @(negedge clk);
            cnt++;
        end
        go_gen = 1'b0;
        chk("fin_seen", 16'(seen), 16'd1);
        chk("fin_latency", 16'(cnt), 16'(expLen + 1));
        chk("seq_rdy_done", 16'(seq_rdy), 16'd1);
        chk("len_out", 16'(len_out), 16'(expLen));
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (fin_gen) extra++;
        end
        chk("fin_single", 16'(extra), 16'd0);
        prevRead = 4'hF;
        for (int a = 0; a < expLen; a++) begin
            rd_addr = 5'(a);
            @(negedge clk);
            chk("rd_digit", 16'(rd_data), 16'(expDig[a]));
`ifdef NO_REPEAT_EN
            if (a > 0) chk("no_repeat", 16'(rd_data != prevRead), 16'd1);
`endif
            prevRead = rd_data;
        end
        if (expLen < 32) begin
            rd_addr = 5'(expLen);
            @(negedge clk);
            chk("rd_oob", 16'(rd_data), 16'hF);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int fins;
        rst     = 1'b0;
        go_gen  = 1'b0;
        seq_len = 6'd0;
        rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("reset_rd_data", 16'(rd_data), 16'hF);
        chk("reset_fin", 16'(fin_gen), 16'd0);
        chk("reset_rdy", 16'(seq_rdy), 16'd0);
        chk("reset_len", 16'(len_out), 16'd0);

        // go_gen issued in cycle 10 after reset release
        repeat (9) @(negedge clk);
        chk("idle_rd_blank", 16'(rd_data), 16'hF);
        runFill(6'd5, 1'b0);
        rd_addr = 5'd7;
        @(negedge clk);
        chk("rd_addr7_len5", 16'(rd_data), 16'hF);

        // Asynchronous reset with a valid sequence stored
        rd_addr = 5'd0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rd_data", 16'(rd_data), 16'hF);
        chk("async_fin", 16'(fin_gen), 16'd0);
        chk("async_rdy", 16'(seq_rdy), 16'd0);
        chk("async_len", 16'(len_out), 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Clamp boundaries
        repeat (2) @(negedge clk);
        runFill(6'd0, 1'b0);
        runFill(6'd40, 1'b0);

        // go_gen re-pulsed during FILL is ignored
        runFill(6'd5, 1'b1);
        runFill(6'd20, 1'b1);

        // Reset on the third FILL cycle, then a clean fill
        seq_len = 6'd5;
        go_gen  = 1'b1;
        @(negedge clk);
        go_gen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_rd_data", 16'(rd_data), 16'hF);
        chk("abort_rdy", 16'(seq_rdy), 16'd0);
        chk("abort_len", 16'(len_out), 16'd0);
        @(negedge clk);
        rst  = 1'b1;
        fins = 0;
        repeat (8) begin
            @(negedge clk);
            if (fin_gen) fins++;
        end
        chk("abort_no_fin", 16'(fins), 16'd0);
        runFill(6'd4, 1'b0);

        // Full-length fills with varied go_gen timing
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            runFill(6'd32, 1'b0);
        end

        // Random requested lengths, including out-of-range values
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            runFill(6'($urandom_range(0, 63)), ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
